// File: rtl/xor4_pkg.sv
// Shared definitions for the 4-bit XOR parity serial path (receiver and transmitter).
package xor4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam int unsigned FRAME_BITS = 7;
    localparam logic        START_LVL  = 1'b0;
    localparam logic        STOP_LVL   = 1'b1;

    // Parity bit for a nibble: even parity gives the plain XOR, odd parity inverts it.
    function automatic logic xor4_par(input logic [3:0] data, input logic odd);
        return data[3] ^ data[2] ^ data[1] ^ data[0] ^ odd;
    endfunction

endpackage

// File: rtl/xor4_parity_calc.sv
// Combinational XOR4 parity generator, shared by both ends of the serial link.
module xor4_parity_calc
    import xor4_pkg::*;
(
    input  logic [3:0] i_data,
    input  logic       i_odd,
    output logic       o_par
);

    assign o_par = xor4_par(i_data, i_odd);

endmodule

// File: rtl/xor4_parity_rx.sv
// Serial start/data/parity/stop frame receiver with XOR4 parity checking and a
// saturating error counter; bit timing is supplied by the external i_bit_en strobe.
module xor4_parity_rx
    import xor4_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter bit PARITY_ODD = 1'b0,
    parameter int ERRCNT_W   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_bit_en,
    input  logic                i_rx,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_valid,
    output logic                o_par_err,
    output logic                o_frm_err,
    output logic                o_busy,
    output logic [ERRCNT_W-1:0] o_err_cnt
);

    if (DATA_W != 4) begin : g_bad_data_w
        $error("xor4_parity_rx: DATA_W must be 4");
    end

    localparam logic [2:0]          LAST_IDX = 3'(DATA_W - 1);
    localparam logic [ERRCNT_W-1:0] CNT_MAX  = {ERRCNT_W{1'b1}};

    rx_state_e             state_q,   state_d;
    logic [DATA_W-1:0]     shreg_q,   shreg_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic                  perr_q,    perr_d;
    logic [DATA_W-1:0]     data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;
    logic                  busy_q,    busy_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                  calc_par_s;
    logic                  err_inc_s;

    xor4_parity_calc u_calc (
        .i_data (shreg_q),
        .i_odd  (PARITY_ODD),
        .o_par  (calc_par_s)
    );

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= 3'd0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next-state logic; the FSM only advances on bit-enable cycles.
    always_comb begin
        state_d = state_q;
        if (i_bit_en) begin
            case (state_q)
                IDLE: begin
                    if (i_rx == START_LVL) state_d = DATA;
                    else                   state_d = IDLE;
                end
                DATA: begin
                    if (bit_idx_q == LAST_IDX) state_d = PARITY;
                    else                       state_d = DATA;
                end
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath and output logic; valid/frame-error strobes self-clear every clock.
    always_comb begin
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        perr_d    = perr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        frm_err_d = 1'b0;
        err_inc_s = 1'b0;
        if (i_bit_en) begin
            case (state_q)
                IDLE: begin
                    if (i_rx == START_LVL) bit_idx_d = 3'd0;
                    else                   bit_idx_d = bit_idx_q;
                end
                DATA: begin
                    shreg_d   = {shreg_q[DATA_W-2:0], i_rx};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
                PARITY: begin
                    perr_d = i_rx ^ calc_par_s;
                end
                STOP: begin
                    if (i_rx == STOP_LVL) begin
                        data_d    = shreg_q;
                        valid_d   = 1'b1;
                        par_err_d = perr_q;
                        err_inc_s = perr_q;
                    end else begin
                        frm_err_d = 1'b1;
                        err_inc_s = 1'b1;
                    end
                end
                default: begin
                    shreg_d = shreg_q;
                end
            endcase
        end else begin
            shreg_d = shreg_q;
        end

        if (err_inc_s && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        else                                     err_cnt_d = err_cnt_q;

        busy_d = (state_d != IDLE);
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_par_err = par_err_q;
    assign o_frm_err = frm_err_q;
    assign o_busy    = busy_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_xor4_parity_rx.sv
// Self-checking bench for xor4_parity_rx: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_xor4_parity_rx;
    import xor4_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, rx = 1'b1;
    logic [3:0] data;
    logic       valid, par_err, frm_err, busy;
    logic [7:0] cnt;

    logic       en_o = 1'b0, rx_o = 1'b1;
    logic [3:0] data_o;
    logic       valid_o, par_err_o, frm_err_o, busy_o;
    logic [7:0] cnt_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] m_data;
    logic       m_perr;
    logic [7:0] m_cnt;

    xor4_parity_rx #(.DATA_W(4), .PARITY_ODD(1'b0), .ERRCNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_bit_en(en), .i_rx(rx),
        .o_data(data), .o_valid(valid), .o_par_err(par_err),
        .o_frm_err(frm_err), .o_busy(busy), .o_err_cnt(cnt)
    );

    xor4_parity_rx #(.DATA_W(4), .PARITY_ODD(1'b1), .ERRCNT_W(8)) dut_odd (
        .i_clk(clk), .i_rst(rst), .i_bit_en(en_o), .i_rx(rx_o),
        .o_data(data_o), .o_valid(valid_o), .o_par_err(par_err_o),
        .o_frm_err(frm_err_o), .o_busy(busy_o), .o_err_cnt(cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Parity rule stated as a count of ones over data plus parity bit.
    function automatic logic ref_perr(input logic [3:0] d, input logic p, input bit odd);
        int ones;
        ones = $countones(d) + int'(p);
        if (odd) return (ones % 2) == 0;
        else     return (ones % 2) != 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0; rx = 1'b1; en_o = 1'b0; rx_o = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_data = 4'd0; m_perr = 1'b0; m_cnt = 8'd0;
    endtask

    // Sends {start, d3..d0, parity, stop} MSB first, with gap idle clocks between bits.
    task automatic send_frame(input logic [6:0] fr, input int gap, input string tag);
        logic pe;
        for (int i = FRAME_BITS - 1; i >= 0; i--) begin
            en = 1'b1; rx = fr[i];
            @(posedge clk); #1;
            en = 1'b0;
            if (i > 0) begin
                tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL %s early_valid bit%0d: got %b want 0", tag, i, valid); end
                tests_run++; if (frm_err !== 1'b0) begin tests_failed++; $display("FAIL %s early_frm_err bit%0d: got %b want 0", tag, i, frm_err); end
                tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL %s busy bit%0d: got %b want 1", tag, i, busy); end
                repeat (gap) begin @(posedge clk); #1; end
            end else begin
                if (fr[0]) begin
                    pe = ref_perr(fr[5:2], fr[1], 1'b0);
                    m_data = fr[5:2];
                    m_perr = pe;
                    if (pe && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end else begin
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end
                tests_run++; if (valid !== fr[0]) begin tests_failed++; $display("FAIL %s valid: got %b want %b", tag, valid, fr[0]); end
                tests_run++; if (frm_err !== ~fr[0]) begin tests_failed++; $display("FAIL %s frm_err: got %b want %b", tag, frm_err, ~fr[0]); end
                tests_run++; if (data !== m_data) begin tests_failed++; $display("FAIL %s data: got %h want %h", tag, data, m_data); end
                tests_run++; if (par_err !== m_perr) begin tests_failed++; $display("FAIL %s par_err: got %b want %b", tag, par_err, m_perr); end
                tests_run++; if (cnt !== m_cnt) begin tests_failed++; $display("FAIL %s err_cnt: got %h want %h", tag, cnt, m_cnt); end
                tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL %s busy_after_stop: got %b want 0", tag, busy); end
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL %s valid_clear: got %b want 0", tag, valid); end
        tests_run++; if (frm_err !== 1'b0) begin tests_failed++; $display("FAIL %s frm_err_clear: got %b want 0", tag, frm_err); end
        tests_run++; if (par_err !== m_perr) begin tests_failed++; $display("FAIL %s par_err_hold: got %b want %b", tag, par_err, m_perr); end
        tests_run++; if (data !== m_data) begin tests_failed++; $display("FAIL %s data_hold: got %h want %h", tag, data, m_data); end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (data !== 4'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", data); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests_run++; if (par_err !== 1'b0) begin tests_failed++; $display("FAIL reset_par_err: got %b want 0", par_err); end
        tests_run++; if (frm_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt: got %h want 0", cnt); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_odd_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_good_frame();
        send_frame(7'b0_1011_1_1, 0, "good");
        tests_run++; if (data !== 4'b1011) begin tests_failed++; $display("FAIL good_data_const: got %h want b", data); end
        idle_check("good");
    endtask

    task automatic test_parity_error();
        send_frame(7'b0_1011_0_1, 0, "perr");
        tests_run++; if (cnt !== 8'd1) begin tests_failed++; $display("FAIL perr_cnt_const: got %h want 1", cnt); end
        send_frame(7'b0_0000_0_1, 0, "perr_recover");
        tests_run++; if (par_err !== 1'b0) begin tests_failed++; $display("FAIL perr_recover_const: got %b want 0", par_err); end
        idle_check("perr");
    endtask

    task automatic test_frame_error();
        send_frame(7'b0_1100_0_0, 1, "frm");
        idle_check("frm");
        tests_run++; if (cnt !== 8'd2) begin tests_failed++; $display("FAIL frm_cnt_const: got %h want 2", cnt); end
    endtask

    task automatic test_odd_slow();
        logic [6:0] fr;
        int vcnt, bcnt, fcnt;
        vcnt = 0; bcnt = 0; fcnt = 0;
        fr = 7'b0_0000_1_1;
        for (int i = FRAME_BITS - 1; i >= 0; i--) begin
            for (int c = 0; c < 3; c++) begin
                en_o = (c == 0); rx_o = fr[i];
                @(posedge clk); #1;
                en_o = 1'b0;
                if (busy_o) bcnt++;
                if (valid_o) vcnt++;
                if (frm_err_o) fcnt++;
            end
        end
        rx_o = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy_o) bcnt++;
            if (valid_o) vcnt++;
        end
        tests_run++; if (vcnt !== 1) begin tests_failed++; $display("FAIL odd_valid_count: got %0d want 1", vcnt); end
        tests_run++; if (bcnt !== 18) begin tests_failed++; $display("FAIL odd_busy_clocks: got %0d want 18", bcnt); end
        tests_run++; if (fcnt !== 0) begin tests_failed++; $display("FAIL odd_frm_count: got %0d want 0", fcnt); end
        tests_run++; if (par_err_o !== ref_perr(4'b0000, 1'b1, 1'b1)) begin tests_failed++; $display("FAIL odd_par_err: got %b want 0", par_err_o); end
        tests_run++; if (data_o !== 4'b0000) begin tests_failed++; $display("FAIL odd_data: got %h want 0", data_o); end
        tests_run++; if (cnt_o !== 8'd0) begin tests_failed++; $display("FAIL odd_cnt: got %h want 0", cnt_o); end
    endtask

    task automatic test_reset_midframe();
        logic [2:0] part;
        part = 3'b010;
        for (int i = 2; i >= 0; i--) begin
            en = 1'b1; rx = part[i];
            @(posedge clk); #1;
        end
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tests_run++; if (cnt !== 8'd0) begin tests_failed++; $display("FAIL midrst_cnt: got %h want 0", cnt); end
        tests_run++; if (data !== 4'd0) begin tests_failed++; $display("FAIL midrst_data: got %h want 0", data); end
        #1 rst = 1'b0;
        m_data = 4'd0; m_perr = 1'b0; m_cnt = 8'd0;
        send_frame(7'b0_0110_0_1, 0, "midrst");
        tests_run++; if (data !== 4'b0110) begin tests_failed++; $display("FAIL midrst_post_data: got %h want 6", data); end
        tests_run++; if (cnt !== 8'd0) begin tests_failed++; $display("FAIL midrst_post_cnt: got %h want 0", cnt); end
    endtask

    task automatic test_random_frames();
        logic [3:0] d;
        logic       p, s;
        for (int n = 0; n < 40; n++) begin
            d = 4'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame({START_LVL, d, p, s}, $urandom_range(0, 2), "rand");
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end
    endtask

    task automatic test_back_to_back();
        send_frame(7'b0_1111_0_1, 0, "b2b_a");
        send_frame(7'b0_1001_1_1, 0, "b2b_b");
        send_frame(7'b0_0001_0_1, 0, "b2b_c");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 256; n++) send_frame(7'b0_0000_1_1, 0, "sat");
        tests_run++; if (cnt !== 8'hFF) begin tests_failed++; $display("FAIL sat_hold: got %h want ff", cnt); end
        send_frame(7'b0_0000_0_0, 0, "sat_frm");
        tests_run++; if (cnt !== 8'hFF) begin tests_failed++; $display("FAIL sat_frm_hold: got %h want ff", cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_odd_slow();
        test_reset_midframe();
        test_back_to_back();
        test_random_frames();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
